ifid_stage: RTL and testbench

IF/ID pipeline stage for the single-issue datapath in the architecture elements catalog. It registers each fetched instruction word and its PC+4 behind a valid/ready handshake with a two-entry skid buffer, so a decode stall never drops an instruction. It presents the 16-bit immediate field directly to the downstream sign extender, along with the register-specifier fields. A synchronous flush supports branch/jump redirect.

---
 rtl/ifid_stage.sv | 160 ++++++++++++++++
 tb/tb_ifid_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_stage.sv
// ifid_stage: IF/ID pipeline register with valid/ready handshake and a
// one-entry skid buffer (two entries total), synchronous flush, and decoded
// register/immediate field outputs.
// Optional feature macro: IFID_BUBBLE_COUNT_EN adds the bubble_cnt output,
// a saturating count of cycles where decode was ready but had nothing valid.
module ifid_stage #(
    parameter int IW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pcplus4,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pcplus4,
    output logic [15:0]   out_imm,
    output logic [4:0]    out_rs,
    output logic [4:0]    out_rt,
    output logic [4:0]    out_rd
`ifdef IFID_BUBBLE_COUNT_EN
    ,
    output logic [15:0]   bubble_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic          r_in_ready;
    logic [IW-1:0] r_main_instr;
    logic [AW-1:0] r_main_pc;
    logic [IW-1:0] r_skid_instr;
    logic [AW-1:0] r_skid_pc;

    logic w_accept;
    logic w_transfer;
    logic w_out_valid;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // out_valid comes straight from the state register, so in_valid has no
    // combinational path to it; in_ready is a register of its own.
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = in_valid & r_in_ready;
    assign w_transfer  = w_out_valid & out_ready;

    // Next-state and data-load selection; flush overrides every other event.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_next_state   = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_accept && w_transfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_next_state = ST_SKID;
                    w_load_skid  = 1'b1;
                end else if (w_transfer) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_transfer) begin
                    w_next_state     = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
        if (flush) begin
            // Only the valid state is dropped; data registers keep stale contents.
            w_next_state     = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register and registered in_ready derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_SKID);
        end
    end

    // Main and skid data registers; loaded only on the selected events.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these data registers are reset because zero contents after reset are part of the contract.
        if (!rst_n) begin
            r_main_instr <= '0;
            r_main_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            if (w_load_main_in) begin
                r_main_instr <= in_instr;
                r_main_pc    <= in_pcplus4;
            end else if (w_load_main_skid) begin
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
            end
            if (w_load_skid) begin
                r_skid_instr <= in_instr;
                r_skid_pc    <= in_pcplus4;
            end
        end
    end

`ifdef IFID_BUBBLE_COUNT_EN
    logic [15:0] r_bubble_cnt;

    // Saturating count of cycles where decode was ready but nothing was valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (out_ready && !w_out_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign out_instr   = r_main_instr;
    assign out_pcplus4 = r_main_pc;
    assign out_imm     = r_main_instr[15:0];
    assign out_rs      = r_main_instr[25:21];
    assign out_rt      = r_main_instr[20:16];
    assign out_rd      = r_main_instr[15:11];

endmodule

// File: tb/tb_ifid_stage.sv
// tb_ifid_stage: directed vector table, hand-written corner sequences and a
// randomized run against a queue-based reference model of ifid_stage.
module tb_ifid_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pcplus4;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pcplus4;
    logic [15:0] out_imm;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
`ifdef IFID_BUBBLE_COUNT_EN
    logic [15:0] bubble_cnt;
`endif

    ifid_stage #(.IW(32), .AW(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pcplus4  (in_pcplus4),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pcplus4 (out_pcplus4),
        .out_imm     (out_imm),
        .out_rs      (out_rs),
        .out_rt      (out_rt),
        .out_rd      (out_rd)
`ifdef IFID_BUBBLE_COUNT_EN
        ,
        .bubble_cnt  (bubble_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of at most two {pc, instr} entries.
    logic [63:0] q[$];
    bit          m_in_ready;
    int          m_bubble;

    task automatic model_reset();
        q.delete();
        m_in_ready = 1'b1;
        m_bubble   = 0;
    endtask

    task automatic model_update();
        bit acc;
        bit xfr;
        acc = in_valid && m_in_ready;
        xfr = (q.size() > 0) && out_ready;
        if ((q.size() == 0) && out_ready && (m_bubble < 65535)) m_bubble++;
        if (flush) begin
            q.delete();
        end else begin
            if (xfr) void'(q.pop_front());
            if (acc) q.push_back({in_pcplus4, in_instr});
        end
        m_in_ready = (q.size() < 2);
    endtask

    // Apply inputs at a falling edge, clock once, return at the next falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        in_valid   = v;
        in_instr   = ins;
        in_pcplus4 = pc;
        out_ready  = ordy;
        flush      = fl;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        logic [31:0] h_ins;
        logic [31:0] h_pc;
        check({tag, "_out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        check({tag, "_in_ready"}, 64'(in_ready), 64'(m_in_ready));
        if (q.size() > 0) begin
            h_ins = q[0][31:0];
            h_pc  = q[0][63:32];
            check({tag, "_instr"}, 64'(out_instr), 64'(h_ins));
            check({tag, "_pc"}, 64'(out_pcplus4), 64'(h_pc));
            check({tag, "_imm"}, 64'(out_imm), 64'(h_ins % 65536));
            check({tag, "_rs"}, 64'(out_rs), 64'((h_ins >> 21) % 32));
            check({tag, "_rt"}, 64'(out_rt), 64'((h_ins >> 16) % 32));
            check({tag, "_rd"}, 64'(out_rd), 64'((h_ins >> 11) % 32));
        end
`ifdef IFID_BUBBLE_COUNT_EN
        check({tag, "_bubble"}, 64'(bubble_cnt), 64'(m_bubble));
`endif
    endtask

    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic        e_ir;
        logic        chk_data;
        logic [31:0] e_ins;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] r_ins;
        logic [31:0] r_pc;
        logic        r_v;
        logic        r_o;
        logic        r_f;

        // Directed sequence: single instruction, stall into skid, flushes.
        vecs[0]  = '{1'b1, 32'h2008FFFC, 32'h00400004, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h2008FFFC, 32'h00400004};
        vecs[1]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b1, 32'h8C430010, 32'h00400008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8C430010, 32'h00400008};
        vecs[3]  = '{1'b1, 32'hAC640020, 32'h0040000C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8C430010, 32'h00400008};
        vecs[4]  = '{1'b1, 32'hDEADBEEF, 32'h00400010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h8C430010, 32'h00400008};
        vecs[5]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hAC640020, 32'h0040000C};
        vecs[6]  = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b1, 32'h11111111, 32'h00400014, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 32'h00400014};
        vecs[8]  = '{1'b1, 32'h22222222, 32'h00400018, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11111111, 32'h00400014};
        vecs[9]  = '{1'b1, 32'h33333333, 32'h0040001C, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[11] = '{1'b1, 32'h44444444, 32'h00400020, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44444444, 32'h00400020};
        vecs[12] = '{1'b1, 32'h55555555, 32'h00400024, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};
        vecs[13] = '{1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_instr   = '0;
        in_pcplus4 = '0;
        out_ready  = 1'b1;
        flush      = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_instr", 64'(out_instr), 64'd0);
        check("rst_out_pc", 64'(out_pcplus4), 64'd0);
`ifdef IFID_BUBBLE_COUNT_EN
        check("rst_bubble", 64'(bubble_cnt), 64'd0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].ins, vecs[i].pc, vecs[i].ordy, vecs[i].fl);
            check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            check($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            if (vecs[i].chk_data) begin
                check($sformatf("vec%0d_instr", i), 64'(out_instr), 64'(vecs[i].e_ins));
                check($sformatf("vec%0d_pc", i), 64'(out_pcplus4), 64'(vecs[i].e_pc));
            end
            if (i == 0) begin
                check("first_imm", 64'(out_imm), 64'h FFFC);
                check("first_rs", 64'(out_rs), 64'd0);
                check("first_rt", 64'(out_rt), 64'd8);
            end
        end

        // Streaming: eight back-to-back instructions with decode always ready.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 32'h20000000 + 32'(i), 32'h00401000 + 32'(4 * i), 1'b1, 1'b0);
            check($sformatf("stream%0d_in_ready", i), 64'(in_ready), 64'd1);
            check($sformatf("stream%0d_out_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("stream%0d_instr", i), 64'(out_instr), 64'h20000000 + 64'(i));
        end
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("stream_drain_out_valid", 64'(out_valid), 64'd0);

        // Asynchronous reset while in SKID.
        step(1'b1, 32'hA0A0A0A0, 32'h00402000, 1'b0, 1'b0);
        step(1'b1, 32'hB0B0B0B0, 32'h00402004, 1'b0, 1'b0);
        check("pre_areset_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("areset_out_valid", 64'(out_valid), 64'd0);
        check("areset_in_ready", 64'(in_ready), 64'd1);
        check("areset_out_instr", 64'(out_instr), 64'd0);
        check("areset_out_pc", 64'(out_pcplus4), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'h01234567, 32'h00403000, 1'b0, 1'b0);
        check("post_areset_out_valid", 64'(out_valid), 64'd1);
        check("post_areset_instr", 64'(out_instr), 64'h01234567);

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            r_v   = 1'($urandom_range(0, 3) != 0);
            r_o   = 1'($urandom_range(0, 2) != 0);
            r_f   = 1'($urandom_range(0, 15) == 0);
            r_ins = $urandom;
            r_pc  = $urandom;
            step(r_v, r_ins, r_pc, r_o, r_f);
            compare_model($sformatf("rnd%0d", i));
        end

        // Bubble counting: idle-ready cycles count, stalled-valid cycles do not.
        in_valid = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        #1;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
`ifdef IFID_BUBBLE_COUNT_EN
        check("bubble_after_idle", 64'(bubble_cnt), 64'd5);
`endif
        step(1'b1, 32'hCAFEF00D, 32'h00404000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            check($sformatf("stall%0d_instr", i), 64'(out_instr), 64'hCAFEF00D);
            check($sformatf("stall%0d_out_valid", i), 64'(out_valid), 64'd1);
        end
`ifdef IFID_BUBBLE_COUNT_EN
        check("bubble_after_stall", 64'(bubble_cnt), 64'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
